// File: rtl/memory_line.sv
// memory_line
//   One addressable row of a small register file. The row holds a WIDTH-bit
//   word in per-bit flip-flops. A word is written on the rising clock edge
//   when the row is selected and write-enabled. The stored word is driven
//   combinationally on dataOut while the row is selected and read-enabled.
//   In every other case dataOut is all zeros, so the outputs of all rows can
//   be OR-combined onto a shared read bus.
//
// Ports
//   clock    in   1      rising-edge clock for storage updates
//   reset    in   1      asynchronous active-low reset; loads RESET_VALUE
//   data1    in   WIDTH  write data, sampled only at the rising edge
//   select   in   1      row select from the address decoder; gates read and write
//   rE       in   1      read enable
//   wE       in   1      write enable
//   dataOut  out  WIDTH  stored word when selected and read-enabled, else zero
module memory_line #(
  parameter int                     WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic             select,
  input  logic             rE,
  input  logic             wE,
  output logic [WIDTH-1:0] dataOut
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] storage_d;
  logic [WIDTH-1:0] storage_q;

  // select gates both directions: a deselected row is fully inert.
  always_comb begin
    wr_en     = select & wE;
    rd_en     = select & rE;
    storage_d = storage_q;
    if (wr_en) begin
      storage_d = data1;
    end
  end

  // Each bit is an independent storage cell. Reset is asynchronous and
  // overrides any write that is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      storage_q <= RESET_VALUE;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        storage_q[i] <= storage_d[i];
      end
    end
  end

  // Read straight from the cells, with no bypass from data1. During a
  // read-while-write cycle the old word is therefore visible until the edge.
  always_comb begin
    dataOut = '0;
    if (rd_en) begin
      dataOut = storage_q;
    end
  end

endmodule

// File: tb/tb_memory_line.sv
module tb_memory_line;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] data1;
  logic         select;
  logic         rE;
  logic         wE;
  logic [W-1:0] dataOut;

  int n_vec;
  int n_err;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] model;

  memory_line #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clock  (clock),
    .reset  (reset),
    .data1  (data1),
    .select (select),
    .rE     (rE),
    .wE     (wE),
    .dataOut(dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: dataOut=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] exp);
    sb_q.push_back(exp);
  endtask

  // Pop the oldest expectation and compare it with the settled output.
  task automatic pop_check(input string tag);
    logic [W-1:0] exp;
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, dataOut=%h", tag, dataOut);
    end else begin
      exp = sb_q.pop_front();
      check_val(tag, dataOut, exp);
    end
  endtask

  task automatic after_edge(input string tag, input logic [W-1:0] exp);
    push_exp(exp);
    @(posedge clock);
    pop_check(tag);
  endtask

  task automatic write_word(input logic [W-1:0] v);
    @(negedge clock);
    select = 1'b1; rE = 1'b1; wE = 1'b1; data1 = v;
    after_edge("write_setup", v);
    @(negedge clock);
    wE = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0; select = 1'b1; rE = 1'b1; wE = 1'b1; data1 = 8'd1;

    // Reset held: edges with a write pending must not change storage.
    #2;
    push_exp(8'd0); pop_check("reset_initial");
    repeat (3) @(posedge clock);
    push_exp(8'd0); pop_check("reset_held_edges");
    @(negedge clock);
    reset = 1'b1;
    push_exp(8'd0); pop_check("reset_release_no_edge");
    after_edge("reset_release_write", 8'd1);

    // Write then hold.
    @(negedge clock);
    data1 = 8'd3;
    after_edge("write_3", 8'd3);
    @(negedge clock);
    wE = 1'b0; data1 = 8'd4;
    repeat (3) @(posedge clock);
    push_exp(8'd3); pop_check("hold_we0");

    // Read gating.
    write_word(8'd5);
    rE = 1'b0;
    push_exp(8'd0); pop_check("read_re0");
    rE = 1'b1;
    push_exp(8'd5); pop_check("read_re1");
    select = 1'b0;
    push_exp(8'd0); pop_check("read_sel0");

    // Deselected write must not corrupt storage.
    write_word(8'd6);
    select = 1'b0; wE = 1'b1; data1 = 8'd7;
    after_edge("desel_write_out", 8'd0);
    @(negedge clock);
    select = 1'b1; wE = 1'b0; rE = 1'b1;
    push_exp(8'd6); pop_check("desel_write_kept");

    // Asynchronous reset between edges.
    write_word(8'd2);
    #2 reset = 1'b0;
    push_exp(8'd0); pop_check("async_reset_out");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    push_exp(8'd0); pop_check("after_reset_kept0");

    // Simultaneous read and write, no bypass.
    write_word(8'd8);
    wE = 1'b1; data1 = 8'hA5;
    push_exp(8'd8); pop_check("rw_before_edge");
    after_edge("rw_after_edge", 8'hA5);

    // data1 changes between edges do not reach storage.
    @(negedge clock);
    wE = 1'b0; data1 = 8'h5A;
    push_exp(8'hA5); pop_check("data_between_edges");

    // Random traffic against a reference model.
    model = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      select = 1'($urandom_range(0, 1));
      rE     = 1'($urandom_range(0, 1));
      wE     = 1'($urandom_range(0, 1));
      data1  = 8'($urandom);
      push_exp((select && rE) ? model : 8'd0);
      pop_check("rand_pre");
      @(posedge clock);
      if (select && wE) model = data1;
      push_exp((select && rE) ? model : 8'd0);
      pop_check("rand_post");
    end

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
